// File: rtl/fir_out_buffer.sv
// First-word-fall-through output FIFO for the FIR sample stream; depth 2^AW.
// Define FIR_OUT_BUFFER_OVF_EN to add the sticky OVF flag for dropped pushes.
module fir_out_buffer #(
  parameter int unsigned N  = 16,
  parameter int unsigned AW = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic          R_IN,
  input  logic [N-1:0]  D_IN,
  input  logic          ACK,
  output logic          R_OUT,
  output logic [N-1:0]  D_OUT,
  output logic          FULL,
  output logic [AW:0]   COUNT
`ifdef FIR_OUT_BUFFER_OVF_EN
  ,
  output logic          OVF
`endif
);

  localparam int unsigned Depth    = 1 << AW;
  localparam logic [AW:0] DepthCnt = (AW+1)'(Depth);

  logic [N-1:0]  mem_q [Depth];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          r_out_q, full_q;
  logic          push, pop;

  always_comb begin
    pop      = EN && r_out_q && ACK;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push     = EN && R_IN && (!full_q || pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      r_out_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      r_out_q  <= (count_d != '0);
      full_q   <= (count_d == DepthCnt);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && push) mem_q[wr_ptr_q] <= D_IN;
  end

  assign R_OUT = r_out_q;
  assign FULL  = full_q;
  assign COUNT = count_q;
  assign D_OUT = r_out_q ? mem_q[rd_ptr_q] : '0;

`ifdef FIR_OUT_BUFFER_OVF_EN
  logic ovf_q;

  always_ff @(posedge CLK) begin
    if (RST) ovf_q <= 1'b0;
    else     ovf_q <= ovf_q | (EN && R_IN && full_q && !pop);
  end

  assign OVF = ovf_q;
`endif

endmodule

// File: tb/tb_fir_out_buffer.sv
// Scoreboard bench for fir_out_buffer: directed scenarios then random traffic.
module tb_fir_out_buffer;

  localparam int N     = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, en, r_in, ack;
  logic [N-1:0]  d_in;
  logic          r_out, full;
  logic [N-1:0]  d_out;
  logic [AW:0]   count;
`ifdef FIR_OUT_BUFFER_OVF_EN
  logic          ovf;
`endif

  fir_out_buffer #(.N(N), .AW(AW)) dut (
    .CLK   (clk),
    .RST   (rst),
    .EN    (en),
    .R_IN  (r_in),
    .D_IN  (d_in),
    .ACK   (ack),
    .R_OUT (r_out),
    .D_OUT (d_out),
    .FULL  (full),
    .COUNT (count)
`ifdef FIR_OUT_BUFFER_OVF_EN
    ,
    .OVF   (ovf)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a queue of accepted samples plus the occupancy it implies.
  logic [N-1:0] exp_q[$];
  int mdl_cnt = 0;
  int chk_cnt = 0;
  bit mdl_ovf = 0;
  bit chk_ovf = 0;
  bit mon_en  = 0;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Applies one cycle of inputs and advances the model to the state after that edge.
  task automatic step(input logic r, input logic e, input logic v, input logic [N-1:0] d,
                      input logic a);
    bit p_pop, p_push;
    @(posedge clk);
    #1;
    rst = r; en = e; r_in = v; d_in = d; ack = a;
    chk_cnt = mdl_cnt;
    chk_ovf = mdl_ovf;
    mon_en  = 1;
    if (r) begin
      mdl_cnt = 0;
      mdl_ovf = 0;
      exp_q.delete();
    end else if (e) begin
      p_pop  = a && (mdl_cnt > 0);
      p_push = v && (mdl_cnt < DEPTH || p_pop);
      if (v && !p_push) mdl_ovf = 1;
      if (p_push) exp_q.push_back(d);
      mdl_cnt = mdl_cnt + int'(p_push) - int'(p_pop);
    end
  endtask

  // Monitor: checks registered status every cycle, head value while valid,
  // and consumes the expected sample on each DUT handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      check("count", int'(count), chk_cnt);
      check("r_out", int'(r_out), int'(chk_cnt != 0));
      check("full",  int'(full),  int'(chk_cnt == DEPTH));
`ifdef FIR_OUT_BUFFER_OVF_EN
      check("ovf", int'(ovf), int'(chk_ovf));
`endif
      if (chk_cnt > 0 && exp_q.size() > 0) check("d_out_head", int'(d_out), int'(exp_q[0]));
      if (!rst && en && r_out && ack) begin
        if (exp_q.size() == 0) check("pop_on_empty", 1, 0);
        else void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; r_in = 1'b0; ack = 1'b0; d_in = '0;
    step(1, 0, 0, 16'h0, 0);
    step(1, 1, 1, 16'h5555, 0);        // push during reset is lost
    step(0, 1, 1, 16'h0001, 0);        // first cycle out of reset accepts
    @(negedge clk);
    check("reset_d_out", int'(d_out), 0);
    step(0, 1, 1, 16'h0002, 0);
    step(0, 1, 1, 16'h0003, 0);
    step(0, 1, 0, 16'h0, 0);
    @(negedge clk);
    check("three_push_count", int'(count), 3);
    check("three_push_head", int'(d_out), 16'h0001);

    // Empty out, then first-word-fall-through latency.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 16'h0, 1);
    step(0, 1, 1, 16'h00A0, 0);
    step(0, 1, 0, 16'h0, 0);
    @(negedge clk);
    check("fwft_head", int'(d_out), 16'h00A0);
    step(0, 1, 0, 16'h0, 1);

    // Overfill: nine pushes into depth eight, last one dropped.
    for (int i = 0; i < 9; i++) step(0, 1, 1, N'(16'h0010 + i), 0);
    step(0, 1, 0, 16'h0, 0);
    // Full with simultaneous push and pop: no drop.
    step(0, 1, 1, 16'h1234, 1);
    step(0, 1, 0, 16'h0, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 16'h0, 1);
    step(0, 1, 1, 16'hBEEF, 1);        // ACK on empty must be ignored

    // Stream 20 samples with ACK toggling to wrap pointers.
    for (int i = 0; i < 20; i++) step(0, 1, 1, N'(16'h0100 + i), i[0]);
    for (int i = 0; i < 12; i++) step(0, 1, 0, 16'h0, 1);

    // Five entries, then freeze for three cycles, then reset.
    for (int i = 0; i < 5; i++) step(0, 1, 1, N'(16'h0200 + i), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 16'hDEAD, 1);
    step(1, 1, 1, 16'hCAFE, 1);
    step(0, 1, 0, 16'h0, 0);

    // Random traffic with occasional freeze and rare reset.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 2) != 0), N'($urandom), ($urandom_range(0, 1) == 1));
    end
    for (int i = 0; i < 10; i++) step(0, 1, 0, 16'h0, 1);
    step(0, 1, 0, 16'h0, 0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
